hilo_multu_unit: RTL and testbench

Multi-cycle unsigned multiplier with architectural HI/LO registers. It sits directly downstream of the control unit: it consumes the 6-bit R-type `Signal` field and serves MULTU (25), MFHI (16) and MFLO (18) in place of the main ALU. While a multiply is in flight it raises a stall toward the pipeline and control logic.

---
 rtl/hilo_multu_unit.sv | 114 +++++++++++
 tb/tb_hilo_multu_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_multu_unit.sv
// Unsigned shift-add multiplier owning the HI/LO pair; also serves MFHI/MFLO reads.
// Latency: MULTU writes HI/LO WIDTH edges after accept (fewer with MULTU_EARLY_TERM_EN); MFHI/MFLO 1 cycle.
// Backpressure: requests are refused while busy; stall tells the requester to hold them.
module hilo_multu_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       Signal,
   input  logic             start,
   input  logic [WIDTH-1:0] dataA,
   input  logic [WIDTH-1:0] dataB,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [2*WIDTH-1:0] mcand, prod, prod_sum;
   logic [WIDTH-1:0]   mplier, mplier_shr;
   logic [CW-1:0]      count;
   logic               is_multu, is_mfhi, is_mflo;
   logic               last_iter;

   assign is_multu   = (Signal == F_MULTU);
   assign is_mfhi    = (Signal == F_MFHI);
   assign is_mflo    = (Signal == F_MFLO);
   assign prod_sum   = mplier[0] ? (prod + mcand) : prod;
   assign mplier_shr = mplier >> 1;

`ifdef MULTU_EARLY_TERM_EN
   // Finish as soon as no multiplier bits remain; product is unchanged.
   assign last_iter = (count == CW'(1)) || (mplier_shr == '0);
`else
   assign last_iter = (count == CW'(1));
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start && is_multu) state_nxt = S_RUN;
         S_RUN:   if (last_iter)         state_nxt = S_DONE;
         S_DONE:                         state_nxt = S_IDLE;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      busy  = (state != S_IDLE);
      stall = start && busy && (is_multu || is_mfhi || is_mflo);
   end

   // Datapath: operand load, shift-add iterations, HI/LO write, read port
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand        <= '0;
         mplier       <= '0;
         prod         <= '0;
         count        <= '0;
         hi           <= '0;
         lo           <= '0;
         done         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         done         <= 1'b0;
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start && is_multu) begin
                  mcand  <= {{WIDTH{1'b0}}, dataA};
                  mplier <= dataB;
                  prod   <= '0;
                  count  <= CW'(WIDTH);
               end else if (start && (is_mfhi || is_mflo)) begin
                  result       <= is_mfhi ? hi : lo;
                  result_valid <= 1'b1;
               end
            end
            S_RUN: begin
               prod   <= prod_sum;
               mcand  <= mcand << 1;
               mplier <= mplier_shr;
               count  <= count - CW'(1);
               if (last_iter) begin
                  {hi, lo} <= prod_sum;
                  done     <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_multu_unit.sv
// Self-checking bench for hilo_multu_unit: directed cases plus random op stream.
// A transaction-level model predicts every output each cycle.
// Held requests exercise the stall path.
module tb_hilo_multu_unit;

   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  Signal = '0;
   logic        start = 1'b0;
   logic [31:0] dataA = '0, dataB = '0;
   logic        busy, stall, done, result_valid;
   logic [31:0] result, hi, lo;

   int errors = 0;
   int checks = 0;

   hilo_multu_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .Signal(Signal), .start(start),
      .dataA(dataA), .dataB(dataB), .busy(busy), .stall(stall),
      .done(done), .result(result), .result_valid(result_valid),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Iteration count the multiply takes for multiplier b.
   function automatic int mul_len(input logic [31:0] b);
`ifdef MULTU_EARLY_TERM_EN
      int h = 0;
      for (int i = 0; i < 32; i++) if (b[i]) h = i + 1;
      return (h == 0) ? 1 : h;
`else
      return 32;
`endif
   endfunction

   // Reference model: counts remaining busy cycles, product from plain arithmetic.
   int          m_left;
   logic [31:0] m_hi, m_lo, m_res;
   logic        m_rv, m_done;
   logic [63:0] m_prod;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_hi = '0; m_lo = '0; m_res = '0;
         m_rv = 1'b0; m_done = 1'b0; m_prod = '0;
      end else begin
         m_rv   = 1'b0;
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 1) begin
               {m_hi, m_lo} = m_prod;
               m_done = 1'b1;
            end
         end else if (start) begin
            if (Signal == F_MULTU) begin
               m_left = mul_len(dataB) + 1;
               m_prod = {32'd0, dataA} * {32'd0, dataB};
            end else if (Signal == F_MFHI) begin
               m_res = m_hi; m_rv = 1'b1;
            end else if (Signal == F_MFLO) begin
               m_res = m_lo; m_rv = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("result_valid", result_valid, m_rv);
            chk("result", result, m_res);
            chk("stall", stall, start && (m_left > 0) &&
                (Signal == F_MULTU || Signal == F_MFHI || Signal == F_MFLO));
         end
      end
   end

   // Drive a request and hold it until an idle edge accepts it; returns at the
   // negedge after the accepting edge with start dropped.
   task automatic issue(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                        output int held);
      logic idle, ok;
      ok = 1'b0;
      held = 0;
      @(negedge clk);
      Signal = s; dataA = a; dataB = b; start = 1'b1;
      for (int i = 0; i < 200; i++) begin
         idle = (m_left == 0);
         @(posedge clk);
         if (idle) begin ok = 1'b1; break; end
         held++;
         @(negedge clk);
      end
      if (!ok) chk("accept_timeout", ok, 1'b1);
      @(negedge clk);
      start = 1'b0;
   endtask

   // From the first cycle after accept: cycle index of done and number of busy cycles.
   task automatic measure(output int n_done, output int n_busy);
      n_done = 0; n_busy = 0;
      for (int k = 1; k < 100; k++) begin
         if (done && n_done == 0) n_done = k;
         if (!busy) break;
         n_busy++;
         @(negedge clk);
      end
   endtask

   initial begin
      int h, nd, nb, exp_nd;
      logic [5:0] s;
      logic [31:0] a, b;

      // Reset held from time zero
      #1;
      chk("rst_hi", hi, 0); chk("rst_lo", lo, 0); chk("rst_busy", busy, 0);
      chk("rst_done", done, 0); chk("rst_rv", result_valid, 0); chk("rst_result", result, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // All-ones operands
      issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h);
      measure(nd, nb);
      chk("ff_busy_cycles", nb, 33);
      chk("ff_done_cycle", nd, 33);
      chk("ff_hi", hi, 32'hFFFF_FFFE);
      chk("ff_lo", lo, 32'h0000_0001);

      // 3 x 5 then reads
      issue(F_MULTU, 32'd3, 32'd5, h);
      measure(nd, nb);
      issue(F_MFLO, 32'd0, 32'd0, h);
      chk("mflo_rv", result_valid, 1); chk("mflo_val", result, 15);
      issue(F_MFHI, 32'd0, 32'd0, h);
      chk("mfhi_rv", result_valid, 1); chk("mfhi_val", result, 0);

      // MFHI arriving mid-multiply is held until the first idle edge
      issue(F_MULTU, 32'h1_0000, 32'h1_0000, h);
      repeat (3) @(negedge clk);
      Signal = F_MFHI; start = 1'b1;
      #1 chk("hold_stall", stall, 1);
      issue(F_MFHI, 32'd0, 32'd0, h);
      chk("hold_waited", h > 0, 1);
      chk("hold_rv", result_valid, 1);
      chk("hold_result", result, 32'h1);
      chk("hold_lo", lo, 0);

      // Reset mid-multiply aborts it
      issue(F_MULTU, 32'd7, 32'd9, h);
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 0); chk("abort_hi", hi, 0); chk("abort_lo", lo, 0);
      chk("abort_done", done, 0); chk("abort_rv", result_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      issue(F_MULTU, 32'd7, 32'd9, h);
      measure(nd, nb);
      chk("redo_lo", lo, 63); chk("redo_hi", hi, 0);

      // Small multipliers: completion time depends on the build
      issue(F_MULTU, 32'h0123_4567, 32'd5, h);
      measure(nd, nb);
`ifdef MULTU_EARLY_TERM_EN
      exp_nd = 4;
`else
      exp_nd = 33;
`endif
      chk("b5_done_cycle", nd, exp_nd);
      chk("b5_lo", lo, 32'h05B0_5B03); chk("b5_hi", hi, 0);
      issue(F_MULTU, 32'hDEAD_BEEF, 32'd0, h);
      measure(nd, nb);
`ifdef MULTU_EARLY_TERM_EN
      exp_nd = 2;
`else
      exp_nd = 33;
`endif
      chk("b0_done_cycle", nd, exp_nd);
      chk("b0_lo", lo, 0); chk("b0_hi", hi, 0);

      // Random op stream, sometimes issued while still busy
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: s = F_MULTU;
            1: s = F_MFHI;
            2: s = F_MFLO;
            default: s = 6'h20;
         endcase
         a = $urandom;
         b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
         issue(s, a, b, h);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      repeat (40) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
